combo_lock_fsm: RTL and testbench
=================================

# combo_lock_fsm

Parametrised combination-lock controller. It sits between the debounced push-button/switch front end and the seven-segment display drivers. It collects `CODE_LENGTH` digits from the switches, one per `enter` pulse, and compares them against a stored code. It counts failed attempts and enforces a timed lockout after `MAX_TRIES` consecutive failures. It exports the entered digits and a status code so the display drivers can render progress and the result.

## Interface
Parameters:
- `CODE_LENGTH`, 3: number of digits per code (≥1).
- `DIGIT_W`, 4: bits per digit.
- `MAX_TRIES`, 3: consecutive failures that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 500_000_000: lockout duration in `clk` cycles (≥1).
- `DEFAULT_CODE`, 12'h309: reset code, `CODE_LENGTH*DIGIT_W` bits; first digit in the MS slot.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  reset, synchronous and active-low.
- `enter`  in  1  single-cycle pulse from the button debouncer `p_edge`.
- `clear`  in  1  single-cycle pulse; aborts the current entry.
- `prog`  in  1  single-cycle pulse; requests code reprogramming (see Configuration).
- `digit_in`  in  `DIGIT_W`  switch value, sampled on `enter`.
- `digits_out`  out  `CODE_LENGTH*DIGIT_W`  captured digits; slot 0 (the first digit) is in the MS position.
- `digit_valid`  out  `CODE_LENGTH`  per-slot filled flag, used for display blanking; bit `CODE_LENGTH-1` corresponds to slot 0.
- `status`  out  3  current state code (package encoding).
- `unlocked`  out  1  high in UNLOCKED.
- `locked_out`  out  1  high in LOCKOUT.
- `tries_left`  out  `$clog2(MAX_TRIES+1)`  remaining attempts.

## Operation
States: ENTRY, CHECK, UNLOCKED, FAIL, LOCKOUT, PROGRAM.
- **ENTRY**
  - On `enter`, write `digit_in` to slot `idx`, set that slot's valid bit, and increment `idx`.
  - On capture of slot `CODE_LENGTH-1`, go to CHECK.
  - On `clear`, zero the digits, valid bits and `idx`; no attempt is consumed.
- **CHECK** (one cycle): compare `digits_out` against the code register.
  - On a match, go to UNLOCKED and set `tries_left` to `MAX_TRIES`.
  - On a mismatch, decrement `tries_left`. If the result is 0, go to LOCKOUT; otherwise go to FAIL.
- **UNLOCKED**
  - `enter` relocks: clear the entry and go to ENTRY. That press is not captured as a digit.
  - `prog` goes to PROGRAM (macro builds only).
- **FAIL**: held until `enter`, which clears the entry and goes to ENTRY. That press is not captured as a digit.
- **LOCKOUT**
  - Start `lockout_timer` on entry to the state.
  - `enter`, `clear` and `prog` are ignored.
  - On `done`, clear the entry, set `tries_left` to `MAX_TRIES`, and go to ENTRY.
- **PROGRAM**
  - Captures digits exactly as ENTRY does.
  - After the last digit, load the code register with the entered digits, clear the entry, and go to ENTRY (locked).
  - `clear` aborts to UNLOCKED with the code unchanged.
- Boundary rules:
  - `enter` and `clear` in the same cycle: `clear` wins.
  - `enter`, `clear` and `prog` are ignored in CHECK.
  - `clear` is ignored in UNLOCKED and FAIL.
  - `tries_left` never underflows.
  - A successful unlock restores the full try count.

## Timing
- Reset (sampled on `clk` with `reset_n` low):
  - State goes to ENTRY.
  - `digits_out` and `digit_valid` go to 0; `idx` goes to 0.
  - `tries_left` goes to `MAX_TRIES`.
  - The code register goes to `DEFAULT_CODE`.
  - `unlocked` and `locked_out` go to 0; `status` goes to ENTRY.
- Reset mid-operation (any state, including LOCKOUT or PROGRAM) restores all of the above, including `DEFAULT_CODE`.
- A captured digit is visible on `digits_out` the cycle after `enter`.
- Last `enter` in cycle N: CHECK in cycle N+1; `unlocked`, FAIL or `locked_out` valid in cycle N+2.
- `locked_out` is high for exactly `LOCKOUT_CYCLES` cycles; ENTRY follows in the next cycle.
- All outputs are registered.

## Configuration
- `COMBO_LOCK_PROG_EN` defined:
  - PROGRAM state is built.
  - `prog` in UNLOCKED enters PROGRAM.
  - The code register is writable.
- `COMBO_LOCK_PROG_EN` undefined:
  - No PROGRAM state.
  - `prog` is ignored; the port remains present.
  - The code is the constant `DEFAULT_CODE`.

## Structure
- Package `combo_lock_pkg` holds:
  - state/status encoding: ENTRY=0, CHECK=1, UNLOCKED=2, FAIL=3, LOCKOUT=4, PROGRAM=5;
  - the code-width helper `CODE_W = CODE_LENGTH*DIGIT_W`.
- Sub-module `lockout_timer`:
  - parameter `CYCLES`;
  - inputs `clk`, `reset_n`, `start`;
  - output `done`, a one-cycle pulse after `CYCLES` cycles;
  - counter width `$clog2(CYCLES)`.

## Test plan
Bench parameters: `CODE_LENGTH`=3, `DIGIT_W`=4, `MAX_TRIES`=3, `LOCKOUT_CYCLES`=20, `DEFAULT_CODE`=12'h309.
- Correct code: enter 3, 0, 9 → `digit_valid` steps 100 → 110 → 111; two cycles after the third `enter`, `unlocked`=1, `status`=2, `tries_left`=3.
- One failure: enter 3, 0, 8 → FAIL (`status`=3), `tries_left`=2; next `enter` → ENTRY with `digits_out`=0 and `digit_valid`=000.
- Lockout: three wrong codes → `locked_out`=1 for exactly 20 cycles with `enter` pulses ignored; then ENTRY with `tries_left`=3.
- Clear: enter 3, 0, then `clear` in the same cycle as an `enter` → `digits_out`=0, `digit_valid`=000, `tries_left` unchanged at 3.
- Reset mid-lockout: `reset_n` low for one cycle during LOCKOUT → ENTRY, `tries_left`=3, `locked_out`=0.
- Programming (`COMBO_LOCK_PROG_EN` defined): unlock, `prog`, enter 1, 2, 3 → ENTRY; 3, 0, 9 now fails and 1, 2, 3 unlocks. With the macro undefined, `prog` has no effect.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// rtl/combo_lock_pkg.sv - state/status encoding and width helper for the combination lock
package combo_lock_pkg;

  // State register value doubles as the exported status code.
  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_FAIL     = 3'd3,
    ST_LOCKOUT  = 3'd4,
    ST_PROGRAM  = 3'd5
  } state_t;

  // Total width of a stored or entered code.
  function automatic int code_w(input int code_length, input int digit_w);
    return code_length * digit_w;
  endfunction

endpackage

// File: rtl/combo_lock_lockout_timer.sv
// rtl/combo_lock_lockout_timer.sv - one-shot countdown that flags the last cycle of the lockout
module lockout_timer #(
  parameter int CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic done
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count;
  logic          running;

  // Load CYCLES-1 on start and count down; the cycle holding zero is the last one of the interval.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= CW'(CYCLES - 1);
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - CW'(1);
      end
    end
  end

  assign done = running && (count == '0);

endmodule

// File: rtl/combo_lock_fsm.sv
// rtl/combo_lock_fsm.sv - combination-lock controller; COMBO_LOCK_PROG_EN builds code reprogramming
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter int CODE_LENGTH    = 3,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 500_000_000,
  parameter logic [code_w(CODE_LENGTH, DIGIT_W)-1:0] DEFAULT_CODE = 12'h309
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      enter,
  input  logic                                      clear,
  input  logic                                      prog,
  input  logic [DIGIT_W-1:0]                        digit_in,
  output logic [code_w(CODE_LENGTH, DIGIT_W)-1:0]   digits_out,
  output logic [CODE_LENGTH-1:0]                    digit_valid,
  output logic [2:0]                                status,
  output logic                                      unlocked,
  output logic                                      locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]            tries_left
);

  localparam int CODE_W = code_w(CODE_LENGTH, DIGIT_W);
  localparam int IDX_W  = (CODE_LENGTH > 1) ? $clog2(CODE_LENGTH) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CODE_LENGTH - 1);
  localparam logic [TRY_W-1:0] FULL_TRIES = TRY_W'(MAX_TRIES);
`ifdef COMBO_LOCK_PROG_EN
  localparam state_t PROG_TARGET = ST_PROGRAM;
`else
  // Without reprogramming, prog leaves the lock sitting in UNLOCKED.
  localparam state_t PROG_TARGET = ST_UNLOCKED;
`endif

  state_t                 state, next_state;
  logic [IDX_W-1:0]       idx;
  logic [CODE_W-1:0]      digits, digits_capt, code;
  logic [CODE_LENGTH-1:0] valid, valid_capt;
  logic [TRY_W-1:0]       tries;
  logic                   capture, last_capture, code_match;
  logic                   timer_start, timer_done;

  assign capture      = enter && !clear && (state == ST_ENTRY || state == ST_PROGRAM);
  assign last_capture = capture && (idx == LAST_IDX);
  assign code_match   = (digits == code);
  assign timer_start  = (next_state == ST_LOCKOUT) && (state != ST_LOCKOUT);

  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (timer_start),
    .done    (timer_done)
  );

  // Entry buffer with the current switch value dropped into slot idx (slot 0 in the MS position).
  always_comb begin
    digits_capt = digits;
    valid_capt  = valid;
    for (int i = 0; i < CODE_LENGTH; i++) begin
      if (idx == IDX_W'(i)) begin
        digits_capt[CODE_W-1-i*DIGIT_W -: DIGIT_W] = digit_in;
        valid_capt[CODE_LENGTH-1-i]                = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_ENTRY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; clear beats enter, and CHECK/LOCKOUT ignore the buttons.
  always_comb begin
    next_state = state;
    case (state)
      ST_ENTRY:    if (last_capture) next_state = ST_CHECK;
      ST_CHECK: begin
        if (code_match)               next_state = ST_UNLOCKED;
        else if (tries <= TRY_W'(1))  next_state = ST_LOCKOUT;
        else                          next_state = ST_FAIL;
      end
      ST_UNLOCKED: begin
        if (enter)     next_state = ST_ENTRY;
        else if (prog) next_state = PROG_TARGET;
      end
      ST_FAIL:     if (enter) next_state = ST_ENTRY;
      ST_LOCKOUT:  if (timer_done) next_state = ST_ENTRY;
`ifdef COMBO_LOCK_PROG_EN
      ST_PROGRAM: begin
        if (clear)             next_state = ST_UNLOCKED;
        else if (last_capture) next_state = ST_ENTRY;
      end
`endif
      default:     next_state = ST_ENTRY;
    endcase
  end

  // Entry buffer and try counter; the final digit of an attempt stays visible through CHECK.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits <= '0;
      valid  <= '0;
      idx    <= '0;
      tries  <= FULL_TRIES;
    end else begin
      case (state)
        ST_ENTRY, ST_PROGRAM: begin
          if (clear || (last_capture && state == ST_PROGRAM)) begin
            digits <= '0;
            valid  <= '0;
            idx    <= '0;
          end else if (capture) begin
            digits <= digits_capt;
            valid  <= valid_capt;
            idx    <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          end
        end
        ST_CHECK: begin
          if (code_match)           tries <= FULL_TRIES;
          else if (tries != '0)     tries <= tries - TRY_W'(1);
        end
        ST_UNLOCKED, ST_FAIL: begin
          if (enter) begin
            digits <= '0;
            valid  <= '0;
            idx    <= '0;
          end
        end
        ST_LOCKOUT: begin
          if (timer_done) begin
            digits <= '0;
            valid  <= '0;
            idx    <= '0;
            tries  <= FULL_TRIES;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef COMBO_LOCK_PROG_EN
  logic [CODE_W-1:0] code_reg;

  // Code register reloads from the completed PROGRAM entry; reset restores the default.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      code_reg <= DEFAULT_CODE;
    end else if (state == ST_PROGRAM && last_capture) begin
      code_reg <= digits_capt;
    end
  end

  assign code = code_reg;
`else
  assign code = DEFAULT_CODE;
`endif

  // Moore outputs decoded from the registered state and datapath.
  always_comb begin
    status      = state;
    unlocked    = (state == ST_UNLOCKED);
    locked_out  = (state == ST_LOCKOUT);
    digits_out  = digits;
    digit_valid = valid;
    tries_left  = tries;
  end

endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb/tb_combo_lock_fsm.sv - randomized self-checking bench for combo_lock_fsm
module tb_combo_lock_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic        prog = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic [11:0] digits_out;
  logic [2:0]  digit_valid;
  logic [2:0]  status;
  logic        unlocked;
  logic        locked_out;
  logic [1:0]  tries_left;

  int total = 0;
  int bad = 0;
  int m_tries = 3;
  int m_code = 'h309;

  always #5 clk = ~clk;

  combo_lock_fsm #(
    .CODE_LENGTH(3), .DIGIT_W(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(20), .DEFAULT_CODE(12'h309)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enter(enter), .clear(clear), .prog(prog),
    .digit_in(digit_in), .digits_out(digits_out), .digit_valid(digit_valid),
    .status(status), .unlocked(unlocked), .locked_out(locked_out), .tries_left(tries_left)
  );

  // Reference: an attempt matching the stored code restores all tries; otherwise one is used.
  task automatic model_attempt(input int c, output int exp_status);
    if (c == m_code) begin
      m_tries = 3;
      exp_status = 2;
    end else begin
      if (m_tries > 0) m_tries = m_tries - 1;
      exp_status = (m_tries == 0) ? 4 : 3;
    end
  endtask

  function automatic int digit_of(input int c, input int i);
    return (c >> (4 * (2 - i))) & 15;
  endfunction

  task automatic press(input int d);
    enter = 1'b1;
    digit_in = 4'(d);
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic try_code(input int c);
    for (int i = 0; i < 3; i++) press(digit_of(c, i));
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_tries = 3;
    m_code = 'h309;
    total++; if (status !== 3'd0) begin bad++; $display("FAIL reset_status got=%0d exp=0", status); end
    total++; if (digits_out !== 12'h0 || digit_valid !== 3'b0) begin bad++; $display("FAIL reset_entry got=%h/%b exp=000/000", digits_out, digit_valid); end
    total++; if (tries_left !== 2'd3) begin bad++; $display("FAIL reset_tries got=%0d exp=3", tries_left); end
    total++; if (unlocked !== 1'b0 || locked_out !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", unlocked, locked_out); end
  endtask

  task automatic test_unlock;
    int d[3] = '{3, 0, 9};
    int acc = 0;
    int exp_st;
    for (int k = 0; k < 3; k++) begin
      press(d[k]);
      acc += d[k] << (4 * (2 - k));
      total++;
      if (digits_out !== 12'(acc) || digit_valid !== 3'(8 - (1 << (2 - k)))) begin
        bad++; $display("FAIL unlock_step%0d got=%h/%b exp=%h/%b", k, digits_out, digit_valid, acc, 3'(8 - (1 << (2 - k))));
      end
    end
    total++; if (status !== 3'd1) begin bad++; $display("FAIL unlock_check_cycle got=%0d exp=1", status); end
    @(negedge clk);
    model_attempt('h309, exp_st);
    total++; if (status !== 3'(exp_st) || unlocked !== 1'b1) begin bad++; $display("FAIL unlock_result got=%0d/%b exp=%0d/1", status, unlocked, exp_st); end
    total++; if (tries_left !== 2'(m_tries)) begin bad++; $display("FAIL unlock_tries got=%0d exp=%0d", tries_left, m_tries); end
    press(5);
    total++; if (status !== 3'd0 || digits_out !== 12'h0 || digit_valid !== 3'b0) begin bad++; $display("FAIL relock got=%0d/%h/%b exp=0/000/000", status, digits_out, digit_valid); end
  endtask

  task automatic test_clear;
    int exp_st;
    press(3);
    press(0);
    enter = 1'b1; clear = 1'b1; digit_in = 4'd9;
    @(negedge clk);
    enter = 1'b0; clear = 1'b0;
    total++; if (digits_out !== 12'h0 || digit_valid !== 3'b0 || status !== 3'd0) begin bad++; $display("FAIL clear_entry got=%h/%b/%0d exp=000/000/0", digits_out, digit_valid, status); end
    total++; if (tries_left !== 2'(m_tries)) begin bad++; $display("FAIL clear_tries got=%0d exp=%0d", tries_left, m_tries); end
    try_code('h309);
    model_attempt('h309, exp_st);
    total++; if (status !== 3'(exp_st)) begin bad++; $display("FAIL clear_then_unlock got=%0d exp=%0d", status, exp_st); end
    press(0);
  endtask

  task automatic test_fail;
    int exp_st;
    try_code('h308);
    model_attempt('h308, exp_st);
    total++; if (status !== 3'(exp_st) || unlocked !== 1'b0) begin bad++; $display("FAIL fail_status got=%0d/%b exp=%0d/0", status, unlocked, exp_st); end
    total++; if (tries_left !== 2'(m_tries)) begin bad++; $display("FAIL fail_tries got=%0d exp=%0d", tries_left, m_tries); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (status !== 3'd3) begin bad++; $display("FAIL fail_clear_ignored got=%0d exp=3", status); end
    press(7);
    total++; if (status !== 3'd0 || digits_out !== 12'h0 || digit_valid !== 3'b0) begin bad++; $display("FAIL fail_exit got=%0d/%h/%b exp=0/000/000", status, digits_out, digit_valid); end
    try_code('h309);
    model_attempt('h309, exp_st);
    total++; if (status !== 3'(exp_st) || tries_left !== 2'(m_tries)) begin bad++; $display("FAIL fail_restore got=%0d/%0d exp=%0d/%0d", status, tries_left, exp_st, m_tries); end
    press(1);
  endtask

  task automatic drive_to_lockout;
    int c;
    int exp_st;
    exp_st = 0;
    for (int a = 0; a < 3 && exp_st != 4; a++) begin
      c = (m_code ^ (1 + $urandom_range(0, 4094))) & 'hfff;
      try_code(c);
      model_attempt(c, exp_st);
      total++; if (status !== 3'(exp_st)) begin bad++; $display("FAIL wrong_code%0d got=%0d exp=%0d", a, status, exp_st); end
      if (exp_st == 3) press($urandom_range(0, 15));
    end
  endtask

  task automatic test_lockout;
    int cnt = 0;
    drive_to_lockout();
    total++; if (locked_out !== 1'b1 || status !== 3'd4) begin bad++; $display("FAIL lockout_entry got=%b/%0d exp=1/4", locked_out, status); end
    while (locked_out === 1'b1 && cnt < 100) begin
      cnt++;
      enter = 1'($urandom); clear = 1'($urandom); prog = 1'($urandom);
      digit_in = 4'($urandom);
      @(negedge clk);
    end
    enter = 1'b0; clear = 1'b0; prog = 1'b0;
    m_tries = 3;
    total++; if (cnt != 20) begin bad++; $display("FAIL lockout_length got=%0d exp=20", cnt); end
    total++; if (status !== 3'd0 || tries_left !== 2'(m_tries) || digit_valid !== 3'b0) begin bad++; $display("FAIL lockout_exit got=%0d/%0d/%b exp=0/%0d/000", status, tries_left, digit_valid, m_tries); end
  endtask

  task automatic test_reset_lockout;
    drive_to_lockout();
    repeat (5) @(negedge clk);
    total++; if (locked_out !== 1'b1) begin bad++; $display("FAIL rst_lock_pre got=%b exp=1", locked_out); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_tries = 3;
    m_code = 'h309;
    total++; if (status !== 3'd0 || tries_left !== 2'd3 || locked_out !== 1'b0) begin bad++; $display("FAIL rst_lock got=%0d/%0d/%b exp=0/3/0", status, tries_left, locked_out); end
  endtask

  task automatic test_prog;
    int exp_st;
    try_code(m_code);
    model_attempt(m_code, exp_st);
    total++; if (status !== 3'd2) begin bad++; $display("FAIL prog_unlock got=%0d exp=2", status); end
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
    total++; if (status !== 3'd5) begin bad++; $display("FAIL prog_enter got=%0d exp=5", status); end
    press(4);
    pulse_clear();
    total++; if (status !== 3'd2) begin bad++; $display("FAIL prog_abort got=%0d exp=2", status); end
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    press(1); press(2); press(3);
    m_code = 'h123;
    total++; if (status !== 3'd0 || digits_out !== 12'h0) begin bad++; $display("FAIL prog_done got=%0d/%h exp=0/000", status, digits_out); end
    try_code('h309);
    model_attempt('h309, exp_st);
    total++; if (status !== 3'(exp_st) || tries_left !== 2'(m_tries)) begin bad++; $display("FAIL prog_old_code got=%0d/%0d exp=%0d/%0d", status, tries_left, exp_st, m_tries); end
    press(0);
    try_code('h123);
    model_attempt('h123, exp_st);
    total++; if (status !== 3'(exp_st) || tries_left !== 2'(m_tries)) begin bad++; $display("FAIL prog_new_code got=%0d/%0d exp=%0d/%0d", status, tries_left, exp_st, m_tries); end
    press(0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_code = 'h309;
    m_tries = 3;
`else
    total++; if (status !== 3'd2) begin bad++; $display("FAIL prog_ignored got=%0d exp=2", status); end
    press(0);
`endif
    try_code('h309);
    model_attempt('h309, exp_st);
    total++; if (status !== 3'(exp_st)) begin bad++; $display("FAIL prog_default_code got=%0d exp=%0d", status, exp_st); end
    press(0);
  endtask

  task automatic test_random;
    int c;
    int acc;
    int exp_st;
    int cnt;
    for (int it = 0; it < 25; it++) begin
      c = ($urandom_range(0, 1) == 1) ? m_code : int'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) begin
        press($urandom_range(0, 15));
        pulse_clear();
        total++; if (digit_valid !== 3'b0) begin bad++; $display("FAIL rnd_clear it=%0d got=%b exp=000", it, digit_valid); end
      end
      acc = 0;
      for (int k = 0; k < 3; k++) begin
        press(digit_of(c, k));
        acc += digit_of(c, k) << (4 * (2 - k));
        total++; if (digits_out !== 12'(acc)) begin bad++; $display("FAIL rnd_digits it=%0d got=%h exp=%h", it, digits_out, acc); end
      end
      @(negedge clk);
      model_attempt(c, exp_st);
      total++;
      if (status !== 3'(exp_st) || tries_left !== 2'(m_tries) || unlocked !== (exp_st == 2) || locked_out !== (exp_st == 4)) begin
        bad++; $display("FAIL rnd_result it=%0d got=%0d/%0d/%b%b exp=%0d/%0d", it, status, tries_left, unlocked, locked_out, exp_st, m_tries);
      end
      if (exp_st == 4) begin
        cnt = 0;
        while (locked_out === 1'b1 && cnt < 100) begin
          cnt++;
          @(negedge clk);
        end
        m_tries = 3;
        total++; if (cnt != 20 || tries_left !== 2'(m_tries)) begin bad++; $display("FAIL rnd_lockout it=%0d got=%0d/%0d exp=20/%0d", it, cnt, tries_left, m_tries); end
      end else begin
        press($urandom_range(0, 15));
      end
      total++; if (status !== 3'd0) begin bad++; $display("FAIL rnd_back_to_entry it=%0d got=%0d exp=0", it, status); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unlock();
    test_clear();
    test_fail();
    test_lockout();
    test_reset_lockout();
    test_prog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
